// File: rtl/dmem_responder_if.sv
// Request/response bundle between the MEM stage and the data-memory responder.
// master = core side (drives req_*), slave = responder (drives ready/rsp_*/busy).
//   req_valid/req_ready : request handshake
//   req_write/funct3/addr/wdata : store flag, width code, byte address, store data
//   rsp_valid/rsp_rdata/rsp_err : one-cycle completion pulse, load data, reject flag
//   busy : request in flight
interface dmem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        busy;

    modport master (
        output req_valid, req_write, req_funct3,
        output req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata,
        input  rsp_err, busy
    );

    modport slave (
        input  req_valid, req_write, req_funct3,
        input  req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata,
        output rsp_err, busy
    );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: word RAM with byte lanes, LATENCY wait states,
// lane select, load sign/zero extension and access-error detection.
//   clock : rising-edge clock
//   reset : synchronous active-high reset (RAM contents kept)
//   bus   : dmem_responder_if.slave request/response bundle
module dmem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input logic             clock,
    input logic             reset,
    dmem_responder_if.slave bus
);
    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;
    localparam bit NO_WAIT = (LATENCY == 0);
    localparam logic [3:0] WAIT_LAST =
        NO_WAIT ? 4'd0 : 4'(LATENCY - 1);

    logic [1:0]  state;
    logic [3:0]  wait_cnt;
    logic        wr_q;
    logic [2:0]  f3_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        err_q;
    logic [31:0] rd_word;
    logic [31:0] mem [DEPTH_WORDS];

    logic          accept;
    logic          enter_resp;
    logic          c_wr;
    logic [2:0]    c_f3;
    logic [31:0]   c_addr;
    logic [31:0]   c_wdata;
    logic [AW-1:0] c_idx;
    logic [1:0]    c_lane;
    logic          fmt_ok;
    logic          c_err;
    logic [3:0]    c_be;
    logic [31:0]   c_wrep;
    logic [31:0]   lane_data;
    logic [31:0]   ld_val;

    assign accept = bus.req_valid && (state == S_IDLE);

    // With no wait states RESP is entered on the accept edge itself.
    assign enter_resp = (state == S_IDLE) ? (accept && NO_WAIT)
                      : ((state == S_WAIT) && (wait_cnt == WAIT_LAST));

    // The RAM access happens on the edge entering RESP; on the accept
    // edge the latched copy is not yet there, so use the live request.
    always_comb begin
        if (state == S_IDLE) begin
            c_wr    = bus.req_write;
            c_f3    = bus.req_funct3;
            c_addr  = bus.req_addr;
            c_wdata = bus.req_wdata;
        end else begin
            c_wr    = wr_q;
            c_f3    = f3_q;
            c_addr  = addr_q;
            c_wdata = wdata_q;
        end
    end

    assign c_idx  = c_addr[AW+1:2];
    assign c_lane = c_addr[1:0];

    always_comb begin
        fmt_ok = 1'b0;
        c_be   = 4'h0;
        c_wrep = c_wdata;
        case (c_f3)
            3'b000, 3'b100: begin
                fmt_ok = !(c_wr && c_f3[2]);
                c_be   = 4'b0001 << c_lane;
                c_wrep = {4{c_wdata[7:0]}};
            end
            3'b001, 3'b101: begin
                fmt_ok = !(c_wr && c_f3[2]) && !c_lane[0];
                c_be   = 4'b0011 << c_lane;
                c_wrep = {2{c_wdata[15:0]}};
            end
            3'b010: begin
                fmt_ok = (c_lane == 2'b00);
                c_be   = 4'hF;
            end
            default: ;
        endcase
    end

    assign c_err = !fmt_ok || ((c_addr >> (AW + 2)) != 32'd0);

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= S_IDLE;
            wait_cnt <= 4'd0;
            wr_q     <= 1'b0;
            f3_q     <= 3'd0;
            addr_q   <= 32'd0;
            wdata_q  <= 32'd0;
            err_q    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        wr_q     <= bus.req_write;
                        f3_q     <= bus.req_funct3;
                        addr_q   <= bus.req_addr;
                        wdata_q  <= bus.req_wdata;
                        err_q    <= c_err;
                        wait_cnt <= 4'd0;
                        state    <= NO_WAIT ? S_RESP : S_WAIT;
                    end
                end
                S_WAIT: begin
                    wait_cnt <= wait_cnt + 4'd1;
                    if (enter_resp) state <= S_RESP;
                end
                S_RESP:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // A reset on the would-be commit edge drops the pending store.
    always_ff @(posedge clock) begin
        if (!reset && enter_resp) begin
            rd_word <= mem[c_idx];
            if (c_wr && !c_err) begin
                for (int i = 0; i < 4; i++) begin
                    if (c_be[i]) begin
                        mem[c_idx][8*i +: 8] <= c_wrep[8*i +: 8];
                    end
                end
            end
        end
    end

    assign lane_data = rd_word >> {addr_q[1:0], 3'b000};

    always_comb begin
        case (f3_q[1:0])
            2'b00: ld_val = f3_q[2]
                ? {24'd0, lane_data[7:0]}
                : {{24{lane_data[7]}}, lane_data[7:0]};
            2'b01: ld_val = f3_q[2]
                ? {16'd0, lane_data[15:0]}
                : {{16{lane_data[15]}}, lane_data[15:0]};
            default: ld_val = lane_data;
        endcase
    end

    assign bus.req_ready = (state == S_IDLE);
    assign bus.busy      = (state != S_IDLE);
    assign bus.rsp_valid = (state == S_RESP);
    assign bus.rsp_err   = (state == S_RESP) && err_q;
    assign bus.rsp_rdata =
        ((state == S_RESP) && !err_q && !wr_q) ? ld_val : 32'd0;
endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: LATENCY=2 and LATENCY=0
// instances checked against a byte-array reference model.
module tb_dmem_responder;
    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    dmem_responder_if b2 ();
    dmem_responder_if b0 ();

    dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(2)) dut2 (
        .clock(clock), .reset(reset), .bus(b2.slave)
    );
    dmem_responder #(.DEPTH_WORDS(64), .LATENCY(0)) dut0 (
        .clock(clock), .reset(reset), .bus(b0.slave)
    );

    int checks = 0;
    int errors = 0;
    logic [7:0] m2 [4096];
    logic [7:0] m0 [256];

    task automatic drive(input int s, input logic v, input logic w,
                         input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] d);
        if (s != 0) begin
            b0.req_valid = v; b0.req_write = w; b0.req_funct3 = f;
            b0.req_addr = a; b0.req_wdata = d;
        end else begin
            b2.req_valid = v; b2.req_write = w; b2.req_funct3 = f;
            b2.req_addr = a; b2.req_wdata = d;
        end
    endtask

    function automatic logic rdy(input int s);
        return (s != 0) ? b0.req_ready : b2.req_ready;
    endfunction
    function automatic logic rvld(input int s);
        return (s != 0) ? b0.rsp_valid : b2.rsp_valid;
    endfunction
    function automatic logic rerr(input int s);
        return (s != 0) ? b0.rsp_err : b2.rsp_err;
    endfunction
    function automatic logic bsy(input int s);
        return (s != 0) ? b0.busy : b2.busy;
    endfunction
    function automatic logic [31:0] rdat(input int s);
        return (s != 0) ? b0.rsp_rdata : b2.rsp_rdata;
    endfunction

    // Reference: memory as bytes; access size from funct3, then the
    // alignment / range / legality rules, then little-endian assembly.
    function automatic void model(input int s, input logic w,
                                  input logic [2:0] f, input logic [31:0] a,
                                  input logic [31:0] d,
                                  output logic [31:0] rd, output logic er);
        int n;
        longint lim;
        logic [31:0] v;
        lim = (s != 0) ? 256 : 4096;
        rd = 32'd0;
        er = 1'b0;
        case (f)
            3'd0: n = 1;
            3'd1: n = 2;
            3'd2: n = 4;
            3'd4: n = w ? 0 : 1;
            3'd5: n = w ? 0 : 2;
            default: n = 0;
        endcase
        if (n == 0) begin er = 1'b1; return; end
        if ((a % n) != 0 || longint'(a) >= lim) begin
            er = 1'b1;
            return;
        end
        v = 32'd0;
        for (int i = 0; i < n; i++) begin
            if (w) begin
                if (s != 0) m0[a + i] = d[8*i +: 8];
                else m2[a + i] = d[8*i +: 8];
            end else begin
                v[8*i +: 8] = (s != 0) ? m0[a + i] : m2[a + i];
            end
        end
        if (!w) begin
            if (n < 4 && !f[2] && v[8*n-1]) v = v | (~32'd0 << (8*n));
            rd = v;
        end
    endfunction

    // One request: wait for ready, measure cycles to rsp_valid, and
    // count cycles where the in-flight outputs are not quiet.
    task automatic xact(input int s, input logic w, input logic [2:0] f,
                        input logic [31:0] a, input logic [31:0] d,
                        output logic [31:0] rd, output logic er,
                        output int lat, output int bad);
        int t;
        bad = 0; lat = -1; rd = 32'd0; er = 1'b0;
        @(negedge clock);
        drive(s, 1'b1, w, f, a, d);
        t = 0;
        while (!rdy(s) && t < 40) begin
            @(negedge clock);
            t++;
        end
        @(negedge clock);
        drive(s, 1'b0, 1'($urandom), 3'($urandom), $urandom, $urandom);
        if (t >= 40) return;
        for (int n = 1; n <= 40; n++) begin
            if (rvld(s)) begin
                lat = n; rd = rdat(s); er = rerr(s);
                break;
            end
            if (rdy(s) || !bsy(s) || rerr(s) || rdat(s) != 32'd0) bad++;
            @(negedge clock);
        end
    endtask

    task automatic op(input int s, input logic w, input logic [2:0] f,
                      input logic [31:0] a, input logic [31:0] d,
                      output logic [31:0] rd, output logic er,
                      output int lat, output int bad,
                      output logic [31:0] erd, output logic eer);
        xact(s, w, f, a, d, rd, er, lat, bad);
        model(s, w, f, a, d, erd, eer);
    endtask

    task automatic test_reset();
        drive(0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
        drive(1, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
        reset = 1'b1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        for (int s = 0; s < 2; s++) begin
            checks++;
            if (rdy(s) !== 1'b1) begin
                errors++; $display("FAIL rst_ready dut%0d got %b want 1", s, rdy(s));
            end
            checks++;
            if (rvld(s) !== 1'b0) begin
                errors++; $display("FAIL rst_valid dut%0d got %b want 0", s, rvld(s));
            end
            checks++;
            if (rdat(s) !== 32'd0) begin
                errors++; $display("FAIL rst_rdata dut%0d got %h want 0", s, rdat(s));
            end
            checks++;
            if (rerr(s) !== 1'b0) begin
                errors++; $display("FAIL rst_err dut%0d got %b want 0", s, rerr(s));
            end
            checks++;
            if (bsy(s) !== 1'b0) begin
                errors++; $display("FAIL rst_busy dut%0d got %b want 0", s, bsy(s));
            end
        end
    endtask

    task automatic test_fill();
        logic [31:0] rd, erd;
        logic er, eer;
        int lat, bad;
        for (int i = 0; i < 64; i++) begin
            op(0, 1'b1, 3'b010, 32'(i * 4), $urandom, rd, er, lat, bad, erd, eer);
            op(1, 1'b1, 3'b010, 32'(i * 4), $urandom, rd, er, lat, bad, erd, eer);
        end
    endtask

    task automatic test_word();
        logic [31:0] rd, erd;
        logic er, eer;
        int lat, bad;
        op(0, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, rd, er, lat, bad, erd, eer);
        checks++;
        if (lat != 3 || er !== 1'b0 || rd !== 32'd0 || bad != 0) begin
            errors++;
            $display("FAIL sw_word lat %0d err %b rdata %h bad %0d want 3 0 0 0",
                     lat, er, rd, bad);
        end
        op(0, 1'b0, 3'b010, 32'h10, 32'd0, rd, er, lat, bad, erd, eer);
        checks++;
        if (lat != 3) begin
            errors++; $display("FAIL lw_latency got %0d want 3", lat);
        end
        checks++;
        if (rd !== 32'hDEADBEEF || er !== 1'b0) begin
            errors++; $display("FAIL lw_word got %h/%b want deadbeef/0", rd, er);
        end
    endtask

    task automatic test_byte();
        logic [31:0] rd, erd;
        logic er, eer;
        int lat, bad;
        op(0, 1'b1, 3'b000, 32'h11, 32'h80, rd, er, lat, bad, erd, eer);
        op(0, 1'b0, 3'b000, 32'h11, 32'd0, rd, er, lat, bad, erd, eer);
        checks++;
        if (rd !== 32'hFFFFFF80 || er !== 1'b0) begin
            errors++; $display("FAIL lb got %h/%b want ffffff80/0", rd, er);
        end
        op(0, 1'b0, 3'b100, 32'h11, 32'd0, rd, er, lat, bad, erd, eer);
        checks++;
        if (rd !== 32'h00000080) begin
            errors++; $display("FAIL lbu got %h want 00000080", rd);
        end
        op(0, 1'b0, 3'b010, 32'h10, 32'd0, rd, er, lat, bad, erd, eer);
        checks++;
        if (rd !== 32'hDEAD80EF) begin
            errors++; $display("FAIL sb_merge got %h want dead80ef", rd);
        end
    endtask

    task automatic test_half();
        logic [31:0] rd, erd;
        logic er, eer;
        int lat, bad;
        op(0, 1'b1, 3'b001, 32'h12, 32'h8001, rd, er, lat, bad, erd, eer);
        op(0, 1'b0, 3'b001, 32'h12, 32'd0, rd, er, lat, bad, erd, eer);
        checks++;
        if (rd !== 32'hFFFF8001) begin
            errors++; $display("FAIL lh got %h want ffff8001", rd);
        end
        op(0, 1'b0, 3'b101, 32'h12, 32'd0, rd, er, lat, bad, erd, eer);
        checks++;
        if (rd !== 32'h00008001) begin
            errors++; $display("FAIL lhu got %h want 00008001", rd);
        end
        op(0, 1'b0, 3'b001, 32'h13, 32'd0, rd, er, lat, bad, erd, eer);
        checks++;
        if (er !== 1'b1 || rd !== 32'd0 || lat != 3) begin
            errors++;
            $display("FAIL lh_misalign err %b rdata %h lat %0d want 1 0 3", er, rd, lat);
        end
        op(0, 1'b1, 3'b010, 32'h16, 32'h55AA55AA, rd, er, lat, bad, erd, eer);
        checks++;
        if (er !== 1'b1) begin
            errors++; $display("FAIL sw_misalign err got %b want 1", er);
        end
        op(0, 1'b0, 3'b010, 32'h14, 32'd0, rd, er, lat, bad, erd, eer);
        checks++;
        if (rd !== erd || er !== 1'b0) begin
            errors++; $display("FAIL sw_misalign_kept got %h want %h", rd, erd);
        end
        op(0, 1'b0, 3'b010, 32'h10, 32'd0, rd, er, lat, bad, erd, eer);
        checks++;
        if (rd !== 32'h800180EF) begin
            errors++; $display("FAIL sh_merge got %h want 800180ef", rd);
        end
    endtask

    task automatic test_errors();
        logic [31:0] rd, erd;
        logic er, eer;
        int lat, bad;
        op(0, 1'b0, 3'b010, 32'd4096, 32'd0, rd, er, lat, bad, erd, eer);
        checks++;
        if (er !== 1'b1 || rd !== 32'd0) begin
            errors++; $display("FAIL lw_range got %b/%h want 1/0", er, rd);
        end
        op(0, 1'b0, 3'b011, 32'h10, 32'd0, rd, er, lat, bad, erd, eer);
        checks++;
        if (er !== 1'b1 || rd !== 32'd0) begin
            errors++; $display("FAIL ld_f3_011 got %b/%h want 1/0", er, rd);
        end
        op(0, 1'b1, 3'b100, 32'h10, 32'h11, rd, er, lat, bad, erd, eer);
        checks++;
        if (er !== 1'b1) begin
            errors++; $display("FAIL st_f3_100 err got %b want 1", er);
        end
        op(0, 1'b0, 3'b010, 32'h10, 32'd0, rd, er, lat, bad, erd, eer);
        checks++;
        if (rd !== 32'h800180EF) begin
            errors++; $display("FAIL st_f3_100_kept got %h want 800180ef", rd);
        end
        op(1, 1'b0, 3'b010, 32'd256, 32'd0, rd, er, lat, bad, erd, eer);
        checks++;
        if (er !== 1'b1 || lat != 1) begin
            errors++; $display("FAIL lw_range_small err %b lat %0d want 1 1", er, lat);
        end
    endtask

    task automatic test_hold();
        int first, second, early;
        logic [31:0] got2, erd;
        logic eer, ok0;
        first = -1; second = -1; early = 0; got2 = 32'd0;
        @(negedge clock);
        ok0 = rdy(0);
        drive(0, 1'b1, 1'b1, 3'b010, 32'h20, 32'hCAFEF00D);
        model(0, 1'b1, 3'b010, 32'h20, 32'hCAFEF00D, erd, eer);
        @(negedge clock);
        drive(0, 1'b1, 1'b0, 3'b010, 32'h20, 32'd0);
        for (int n = 1; n <= 12; n++) begin
            if (n > 1) @(negedge clock);
            if (n == 5) drive(0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
            if (rvld(0)) begin
                if (first < 0) first = n;
                else begin second = n; got2 = rdat(0); end
            end
            if (n <= 3 && rdy(0)) early++;
        end
        model(0, 1'b0, 3'b010, 32'h20, 32'd0, erd, eer);
        checks++;
        if (ok0 !== 1'b1 || early != 0) begin
            errors++; $display("FAIL hold_ready idle %b early %0d want 1 0", ok0, early);
        end
        checks++;
        if (first != 3 || second != 7) begin
            errors++; $display("FAIL hold_timing got %0d,%0d want 3,7", first, second);
        end
        checks++;
        if (got2 !== erd) begin
            errors++; $display("FAIL hold_data got %h want %h", got2, erd);
        end
    endtask

    task automatic test_random();
        logic [31:0] rd, erd, a;
        logic er, eer, w;
        logic [2:0] f;
        int lat, bad;
        for (int i = 0; i < 80; i++) begin
            w = 1'($urandom_range(0, 1));
            f = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 7))
                0: a = 32'h1000 + $urandom_range(0, 63);
                1: a = $urandom;
                default: a = $urandom_range(0, 255);
            endcase
            op(0, w, f, a, $urandom, rd, er, lat, bad, erd, eer);
            checks++;
            if (lat != 3 || bad != 0) begin
                errors++; $display("FAIL rnd_timing %0d lat %0d bad %0d", i, lat, bad);
            end
            checks++;
            if (rd !== erd || er !== eer) begin
                errors++;
                $display("FAIL rnd_data %0d w%b f%0d a %h got %h/%b want %h/%b",
                         i, w, f, a, rd, er, erd, eer);
            end
        end
    endtask

    task automatic test_back_to_back();
        int cyc, last, t, sz;
        logic w;
        logic [2:0] f;
        logic [31:0] a, d, erd;
        logic eer;
        logic [2:0] lf [5];
        lf = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        cyc = 0; last = 0;
        @(negedge clock);
        for (int i = 0; i < 20; i++) begin
            w = 1'($urandom_range(0, 1));
            f = w ? 3'($urandom_range(0, 2)) : lf[$urandom_range(0, 4)];
            sz = (f[1:0] == 2'd0) ? 1 : (f[1:0] == 2'd1) ? 2 : 4;
            a = 32'($urandom_range(0, 63) * 4 + sz * $urandom_range(0, 4 / sz - 1));
            d = $urandom;
            drive(1, 1'b1, w, f, a, d);
            t = 0;
            while (!rdy(1) && t < 10) begin
                @(negedge clock); cyc++; t++;
            end
            if (i > 0) begin
                checks++;
                if (cyc - last != 2) begin
                    errors++; $display("FAIL b2b_spacing %0d got %0d want 2", i, cyc - last);
                end
            end
            last = cyc;
            @(negedge clock); cyc++;
            model(1, w, f, a, d, erd, eer);
            checks++;
            if (rvld(1) !== 1'b1 || rdat(1) !== erd || rerr(1) !== eer) begin
                errors++;
                $display("FAIL b2b_rsp %0d valid %b got %h/%b want %h/%b",
                         i, rvld(1), rdat(1), rerr(1), erd, eer);
            end
        end
        drive(1, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
    endtask

    task automatic test_reset_mid();
        int seen;
        logic [31:0] rd, erd;
        logic er, eer;
        int lat, bad;
        seen = 0;
        @(negedge clock);
        drive(0, 1'b1, 1'b1, 3'b010, 32'h20, 32'h12345678);
        @(negedge clock);
        drive(0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        checks++;
        if (rdy(0) !== 1'b1 || bsy(0) !== 1'b0) begin
            errors++; $display("FAIL mid_rst_idle ready %b busy %b want 1 0", rdy(0), bsy(0));
        end
        for (int k = 0; k < 5; k++) begin
            if (rvld(0)) seen++;
            @(negedge clock);
        end
        checks++;
        if (seen != 0) begin
            errors++; $display("FAIL mid_rst_rsp got %0d pulses want 0", seen);
        end
        op(0, 1'b0, 3'b010, 32'h20, 32'd0, rd, er, lat, bad, erd, eer);
        checks++;
        if (rd !== erd || er !== 1'b0) begin
            errors++; $display("FAIL mid_rst_kept got %h want %h", rd, erd);
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_word();
        test_byte();
        test_half();
        test_errors();
        test_hold();
        test_random();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
